ir_dtrm_gen: RTL
================

// Module: ir_dtrm_gen
// PURPOSE
// Upstream conditioning stage for IR heading fusion. Consumes raw left/right IR
// samples and produces qualified wall-opening flags (lft_opn/rght_opn), the
// signed 9-bit derivative term IR_Dtrm and the en_fusion qualifier. These drive
// the IR heading-adjust math stage directly. Sequential: debounced hysteresis
// per side, a diff history shift register, and a sample-starvation timeout.
// PARAMETERS
// OPN_THRES  12'h111  reading below this counts toward "opening"
// OPN_HYST   12'h040  reading must exceed OPN_THRES+OPN_HYST to count toward "closed"
// DEB_CNT    3        consecutive qualifying samples needed to toggle an opn flag
// D_DEPTH    4        diff history depth; derivative spans D_DEPTH samples
// DSHIFT     1        arithmetic right shift applied to raw derivative
// TIMEOUT    50000    clk cycles without IR_vld before fusion is dropped
// PORTS
// clk       in   1   system clock, all state on posedge
// rst       in   1   asynchronous, active-high reset
// IR_vld    in   1   one-cycle strobe: lft_IR/rght_IR hold a new sample
// lft_IR    in   12  unsigned left IR reading
// rght_IR   in   12  unsigned right IR reading
// lft_opn   out  1   registered, debounced left-opening flag
// rght_opn  out  1   registered, debounced right-opening flag
// IR_Dtrm   out  9   signed derivative term, registered
// en_fusion out  1   history full and samples fresh
// dtrm_vld  out  1   one-cycle pulse, outputs updated from the last sample
// BEHAVIOUR
// - Reset: lft_opn=0, rght_opn=0, IR_Dtrm=0, en_fusion=0, dtrm_vld=0,
//   history cleared, fill=0, debounce and timeout counters 0. Applies immediately.
// - Latency: all outputs update on the clk edge after the IR_vld cycle;
//   dtrm_vld pulses in that same cycle. Samples are ignored when IR_vld=0.
// - Opening qualifier, per side: the debounce counter increments on a sample
//   arguing against the current flag (flag=0 and IR<OPN_THRES, or
//   flag=1 and IR>OPN_THRES+OPN_HYST). Any other sample resets it to 0.
//   When it reaches DEB_CNT, the flag toggles and the counter returns to 0.
//   Readings inside the hysteresis band hold the flag and reset the counter.
// - Diff: IR_diff = {1'b0,lft_IR}-{1'b0,rght_IR}, 13-bit signed.
// - Derivative: on a sample where fill==D_DEPTH, D_raw = IR_diff - hist[oldest].
//   D_raw is 14-bit signed. IR_Dtrm = sat9(D_raw >>> DSHIFT), clamped to [-256,255].
//   When fill<D_DEPTH, IR_Dtrm=0.
// - History: when both flags are 0 after this sample's update, shift IR_diff
//   in, drop the oldest entry, and increment fill (saturates at D_DEPTH).
// - Flush: if either opn flag toggles on this sample, or both flags are 1, then
//   fill=0 and IR_Dtrm=0. That sample is not stored.
// - en_fusion = (fill==D_DEPTH) registered; it drops the same edge fill clears.
// - Timeout: counter resets on IR_vld, otherwise increments (saturating).
//   Reaching TIMEOUT-1 with no IR_vld gives en_fusion=0 and a history flush;
//   opn flags are retained. IR_vld in the same cycle as the hit wins: no flush.
// STRUCTURE
// - Package ir_pkg: NOM_IR, OPN_THRES/OPN_HYST defaults, typedef logic signed
//   [12:0] ir_diff_t, function sat9(input signed [13:0]).
// - Sub-module ir_opn_qual (hysteresis + debounce counter + flag), instanced
//   once per side. The history/derivative/timeout logic stays in this module.
// TESTING
// - Reset with inputs active -> all outputs 0; released, still 0 until first IR_vld.
// - lft=rght=12'h970 x4 -> en_fusion=1 after 4th, IR_Dtrm=0; 5th lft=12'h9F0,
//   rght=12'h8F0 -> IR_Dtrm=128, dtrm_vld pulse.
// - Full zero-diff history, then lft=12'hFFF,rght=0 -> IR_Dtrm=255; lft=0,
//   rght=12'hFFF -> IR_Dtrm=-256.
// - lft_IR=12'h100 x3 -> lft_opn=1 on 3rd, en_fusion=0; 12'h140 x5 stays open;
//   12'h160 x3 -> lft_opn=0; 12'h160,12'h140,12'h160 does not clear.
// - Full history, then no IR_vld for TIMEOUT cycles -> en_fusion=0, opn flags unchanged.
//   Repeat with IR_vld on the terminal cycle -> en_fusion stays 1.
// - Assert rst mid-fill (fill=2, lft debounce=2) -> everything 0.
//   After release, 4 samples are needed for en_fusion.

Source files
------------

// File: rtl/ir_dtrm_gen_pkg.sv
// Shared types, default tuning values and the derivative saturation helper
// for the IR heading-fusion conditioning stage.
package ir_pkg;

  localparam logic [11:0] NOM_IR        = 12'h970;
  localparam logic [11:0] OPN_THRES_DEF = 12'h111;
  localparam logic [11:0] OPN_HYST_DEF  = 12'h040;
  localparam int          DEB_CNT_DEF   = 3;
  localparam int          D_DEPTH_DEF   = 4;
  localparam int          DSHIFT_DEF    = 1;
  localparam int          TIMEOUT_DEF   = 50000;

  typedef logic signed [12:0] ir_diff_t;
  typedef logic signed [13:0] ir_draw_t;

  // Clamp a 14-bit signed derivative into the 9-bit signed output range.
  function automatic logic signed [8:0] sat9(input logic signed [13:0] d);
    if (d > 14'sd255)
      return 9'sd255;
    else if (d < -14'sd256)
      return $signed(9'h100);
    else
      return d[8:0];
  endfunction

endpackage

// File: rtl/ir_dtrm_gen_if.sv
// Sample/derivative bus between the IR front end and the fusion math stage.
interface ir_dtrm_gen_if;

  // IR_vld is a one-cycle strobe qualifying lft_IR/rght_IR; there is no ready,
  // every strobed sample is consumed. dtrm_vld is the matching output strobe.
  logic              IR_vld;
  logic [11:0]       lft_IR;
  logic [11:0]       rght_IR;
  logic              lft_opn;
  logic              rght_opn;
  logic signed [8:0] IR_Dtrm;
  logic              en_fusion;
  logic              dtrm_vld;

  modport master (
    output IR_vld, lft_IR, rght_IR,
    input  lft_opn, rght_opn, IR_Dtrm, en_fusion, dtrm_vld
  );

  modport slave (
    input  IR_vld, lft_IR, rght_IR,
    output lft_opn, rght_opn, IR_Dtrm, en_fusion, dtrm_vld
  );

endinterface

// File: rtl/ir_dtrm_gen_opn_qual.sv
// Per-side wall-opening qualifier: hysteresis comparison plus a debounce
// counter that toggles the flag after DEB_CNT consecutive contrary samples.
module ir_opn_qual
  import ir_pkg::*;
#(
  parameter logic [11:0] OPN_THRES = OPN_THRES_DEF,
  parameter logic [11:0] OPN_HYST  = OPN_HYST_DEF,
  parameter int          DEB_CNT   = DEB_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic [11:0] ir,
  output logic        opn,
  output logic        opn_nxt,
  output logic        tgl
);

  localparam int          CW        = $clog2(DEB_CNT + 1);
  localparam logic [12:0] CLOSE_LVL = {1'b0, OPN_THRES} + {1'b0, OPN_HYST};

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          against;

  // A sample "argues against" the flag when it points to the other state;
  // readings inside the hysteresis band never do.
  always_comb begin
    against = opn ? ({1'b0, ir} > CLOSE_LVL) : (ir < OPN_THRES);
    cnt_nxt = cnt;
    tgl     = 1'b0;
    if (smpl_vld) begin
      if (!against) begin
        cnt_nxt = '0;
      end else if (cnt == CW'(DEB_CNT - 1)) begin
        cnt_nxt = '0;
        tgl     = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
    opn_nxt = opn ^ tgl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      opn <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      opn <= opn_nxt;
    end
  end

endmodule

// File: rtl/ir_dtrm_gen.sv
// IR conditioning top: opening flags, diff history, saturated derivative
// term and the fusion-enable qualifier with sample-starvation timeout.
module ir_dtrm_gen
  import ir_pkg::*;
#(
  parameter logic [11:0] OPN_THRES = OPN_THRES_DEF,
  parameter logic [11:0] OPN_HYST  = OPN_HYST_DEF,
  parameter int          DEB_CNT   = DEB_CNT_DEF,
  parameter int          D_DEPTH   = D_DEPTH_DEF,
  parameter int          DSHIFT    = DSHIFT_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  ir_dtrm_gen_if.slave bus
);

  localparam int            FW     = $clog2(D_DEPTH + 1);
  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FULL   = FW'(D_DEPTH);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  logic              lft_opn, lft_nxt, lft_tgl;
  logic              rght_opn, rght_nxt, rght_tgl;
  ir_diff_t          hist [D_DEPTH];
  ir_diff_t          ir_diff;
  ir_draw_t          d_raw;
  ir_draw_t          d_shift;
  logic [FW-1:0]     fill, fill_nxt;
  logic [TW-1:0]     to_cnt;
  logic signed [8:0] dtrm, dtrm_nxt;
  logic              en_fusion, dtrm_vld;
  logic              full, flush, shift, to_hit;

  ir_opn_qual #(.OPN_THRES(OPN_THRES), .OPN_HYST(OPN_HYST), .DEB_CNT(DEB_CNT)) u_lft (
    .clk      (clk),
    .rst      (rst),
    .smpl_vld (bus.IR_vld),
    .ir       (bus.lft_IR),
    .opn      (lft_opn),
    .opn_nxt  (lft_nxt),
    .tgl      (lft_tgl)
  );

  ir_opn_qual #(.OPN_THRES(OPN_THRES), .OPN_HYST(OPN_HYST), .DEB_CNT(DEB_CNT)) u_rght (
    .clk      (clk),
    .rst      (rst),
    .smpl_vld (bus.IR_vld),
    .ir       (bus.rght_IR),
    .opn      (rght_opn),
    .opn_nxt  (rght_nxt),
    .tgl      (rght_tgl)
  );

  always_comb begin
    ir_diff = $signed({1'b0, bus.lft_IR}) - $signed({1'b0, bus.rght_IR});
    d_raw   = $signed({ir_diff[12], ir_diff}) - $signed({hist[D_DEPTH-1][12], hist[D_DEPTH-1]});
    d_shift = d_raw >>> DSHIFT;
    full    = (fill == FULL);
    // Any flag change or a double opening invalidates the history window.
    flush   = lft_tgl | rght_tgl | (lft_nxt & rght_nxt);
    shift   = !flush && !lft_nxt && !rght_nxt;
    to_hit  = !bus.IR_vld && (to_cnt == TO_MAX);

    fill_nxt = fill;
    dtrm_nxt = dtrm;
    if (bus.IR_vld) begin
      if (flush) begin
        fill_nxt = '0;
        dtrm_nxt = '0;
      end else begin
        dtrm_nxt = full ? sat9(d_shift) : 9'sd0;
        if (shift && !full)
          fill_nxt = fill + FW'(1);
      end
    end else if (to_hit) begin
      fill_nxt = '0;
      dtrm_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D_DEPTH; i++)
        hist[i] <= '0;
      fill      <= '0;
      dtrm      <= '0;
      en_fusion <= 1'b0;
      dtrm_vld  <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (bus.IR_vld && shift) begin
        hist[0] <= ir_diff;
        for (int i = 1; i < D_DEPTH; i++)
          hist[i] <= hist[i-1];
      end
      fill      <= fill_nxt;
      dtrm      <= dtrm_nxt;
      en_fusion <= (fill_nxt == FULL);
      dtrm_vld  <= bus.IR_vld;
      if (bus.IR_vld)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TW'(1);
    end
  end

  assign bus.lft_opn   = lft_opn;
  assign bus.rght_opn  = rght_opn;
  assign bus.IR_Dtrm   = dtrm;
  assign bus.en_fusion = en_fusion;
  assign bus.dtrm_vld  = dtrm_vld;

endmodule
